// File: rtl/ysyx_bus_arbiter.sv
// Single-outstanding arbiter between IFU reads and LSU reads/writes onto one AXI-lite-style
// memory port, with fixed priority and a per-transaction timeout.
module ysyx_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TMO_W  = 8
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_arvalid,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_rvalid,
    output logic                ifu_err,

    input  logic                lsu_arvalid,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic                lsu_awvalid,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_rvalid,
    output logic                lsu_bvalid,
    output logic                lsu_err,

    output logic                mem_arvalid,
    output logic [ADDR_W-1:0]   mem_araddr,
    input  logic                mem_arready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic [1:0]          mem_rresp,
    output logic                mem_rready,
    output logic                mem_awvalid,
    output logic [ADDR_W-1:0]   mem_awaddr,
    input  logic                mem_awready,
    output logic                mem_wvalid,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_wready,
    input  logic                mem_bvalid,
    input  logic [1:0]          mem_bresp,
    output logic                mem_bready
);

    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        StIdle,
        StIfuAr,
        StIfuR,
        StLsuAr,
        StLsuR,
        StLsuW,
        StLsuB
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                aw_pend_q, aw_pend_d;
    logic                w_pend_q, w_pend_d;
    logic                tmo_hit;

    assign tmo_hit = (state_q != StIdle) && (tmo_q == {TMO_W{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            tmo_q     <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            tmo_q     <= tmo_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        unique case (state_q)
            StIdle: begin
                if (lsu_awvalid) begin
                    state_d   = StLsuW;
                    addr_d    = lsu_awaddr;
                    wdata_d   = lsu_wdata;
                    wstrb_d   = lsu_wstrb;
                    aw_pend_d = 1'b1;
                    w_pend_d  = 1'b1;
                end else if (lsu_arvalid) begin
                    state_d = StLsuAr;
                    addr_d  = lsu_araddr;
                end else if (ifu_arvalid) begin
                    state_d = StIfuAr;
                    addr_d  = ifu_araddr;
                end
            end
            StIfuAr: begin
                if (tmo_hit)          state_d = StIdle;
                else if (mem_arready) state_d = StIfuR;
            end
            StLsuAr: begin
                if (tmo_hit)          state_d = StIdle;
                else if (mem_arready) state_d = StLsuR;
            end
            StIfuR, StLsuR: begin
                if (mem_rvalid || tmo_hit) state_d = StIdle;
            end
            StLsuW: begin
                if (tmo_hit) begin
                    state_d = StIdle;
                end else begin
                    if (mem_awready) aw_pend_d = 1'b0;
                    if (mem_wready)  w_pend_d  = 1'b0;
                    if (!aw_pend_d && !w_pend_d) state_d = StLsuB;
                end
            end
            StLsuB: begin
                if (mem_bvalid || tmo_hit) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Counter restarts on every state entry so each phase gets its own budget.
        if (state_d == StIdle || state_d != state_q) tmo_d = '0;
        else                                         tmo_d = tmo_q + TMO_W'(1);
    end

    assign mem_araddr = addr_q;
    assign mem_awaddr = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wstrb  = wstrb_q;

    always_comb begin
        mem_arvalid = 1'b0;
        mem_awvalid = 1'b0;
        mem_wvalid  = 1'b0;
        mem_rready  = 1'b0;
        mem_bready  = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = '0;
        ifu_err     = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_bvalid  = 1'b0;
        lsu_rdata   = '0;
        lsu_err     = 1'b0;
        unique case (state_q)
            StIfuAr: begin
                mem_arvalid = !tmo_hit;
                ifu_rvalid  = tmo_hit;
                ifu_err     = tmo_hit;
            end
            StIfuR: begin
                mem_rready = 1'b1;
                if (mem_rvalid) begin
                    ifu_rvalid = 1'b1;
                    ifu_rdata  = mem_rdata;
                    ifu_err    = (mem_rresp != 2'b00);
                end else if (tmo_hit) begin
                    ifu_rvalid = 1'b1;
                    ifu_err    = 1'b1;
                end
            end
            StLsuAr: begin
                mem_arvalid = !tmo_hit;
                lsu_rvalid  = tmo_hit;
                lsu_err     = tmo_hit;
            end
            StLsuR: begin
                mem_rready = 1'b1;
                if (mem_rvalid) begin
                    lsu_rvalid = 1'b1;
                    lsu_rdata  = mem_rdata;
                    lsu_err    = (mem_rresp != 2'b00);
                end else if (tmo_hit) begin
                    lsu_rvalid = 1'b1;
                    lsu_err    = 1'b1;
                end
            end
            StLsuW: begin
                mem_awvalid = aw_pend_q && !tmo_hit;
                mem_wvalid  = w_pend_q && !tmo_hit;
                lsu_bvalid  = tmo_hit;
                lsu_err     = tmo_hit;
            end
            StLsuB: begin
                mem_bready = 1'b1;
                if (mem_bvalid) begin
                    lsu_bvalid = 1'b1;
                    lsu_err    = (mem_bresp != 2'b00);
                end else if (tmo_hit) begin
                    lsu_bvalid = 1'b1;
                    lsu_err    = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
